uart_xcvr: RTL and testbench
============================

# uart_xcvr

Parametrised UART transceiver that replaces the fixed-format UART on the Nios II system bus path with a standalone, directly driven serial block. It has a configurable frame format (data bits, parity, stop bits), 16x-oversampled reception, a transmit FIFO and receive error reporting. It sits between the board `rxd`/`txd` pins and fabric logic in the `clk_100m` domain, using valid/ready handshakes on both sides.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `BAUD`, default 115200: line rate. Oversample divisor `DIV = CLK_HZ/(16*BAUD)` is truncated and must be ≥1. One bit time is `16*DIV` clocks.
- `DATA_BITS`, default 8: legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `TX_DEPTH`, default 16: TX FIFO entries, power of two, 2..64.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: word to send.
- `tx_valid` in 1 / `tx_ready` out 1: TX handshake. `tx_ready` = FIFO not full.
- `tx_busy` out 1: FIFO non-empty or frame in progress.
- `rx_data` out DATA_BITS: received word.
- `rx_valid` out 1 / `rx_ready` in 1: RX handshake.
- `rx_parity_err` out 1 and `rx_frame_err` out 1: qualifiers for `rx_data`, meaningful while `rx_valid`.
- `rx_overrun` out 1: one-cycle pulse when a received word is dropped.
- `rxd` in 1: serial input, asynchronous.
- `txd` out 1: serial output, idles high.

## Operation
- **Frame format:** start bit (0), then DATA_BITS data bits LSB first, then optional parity, then STOP_BITS stop bits (1).
  - Odd parity: XOR of data bits and parity bit = 1.
  - Even parity: that XOR = 0.
- **TX path:**
  - A write occurs on `tx_valid & tx_ready`. A write while full is ignored.
  - TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE, or → START directly if the FIFO is non-empty.
  - A bit counter of `16*DIV` clocks is restarted on leaving IDLE.
- **RX path:**
  - `rxd` passes through a 2-flop synchroniser; both flops reset to 1.
  - RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - A falling edge of the synchronised `rxd` in IDLE starts the frame.
  - START samples at tick 7 (each tick = DIV clocks). A high sample is a false start: return to IDLE, no output.
  - Each later bit is sampled 16 ticks after the previous sample.
  - In STOP, only the first stop bit is sampled. A low sample sets `rx_frame_err`; the word is still delivered.
  - The FSM returns to IDLE immediately after the stop sample.
- **RX holding register:**
  - On frame completion, data and error flags load and `rx_valid` is set.
  - If `rx_valid` is already high and is not being consumed that cycle, the new word is dropped, the old one is kept, and `rx_overrun` pulses.
  - If completion coincides with the `rx_valid & rx_ready` handshake, the new word loads and there is no overrun.
- **Break condition** (rxd low for the whole frame): delivers data 0 with `rx_frame_err` = 1.

## Timing
- **Reset values:**
  - Outputs: `txd` = 1, `tx_ready` = 1, `tx_busy` = 0, `rx_valid` = 0, `rx_data` = 0, all error flags 0.
  - Internal: FIFO empty, both FSMs IDLE.
- **Reset mid-frame:** asserting reset aborts the frame. `txd` goes high asynchronously and the FIFO contents are lost.
- **TX latency:** with the FIFO empty and TX in IDLE, a write accepted at edge N makes `txd` fall at edge N+2.
- **TX bit timing:** each bit is held exactly `16*DIV` clocks. The stop period is `STOP_BITS*16*DIV` clocks.
- **Back-to-back TX:** the next start bit begins on the clock after the stop period ends, with zero idle gap.
- **`tx_ready`:** deasserts on the edge the FIFO becomes full. It reasserts on the edge after a pop.
- **RX latency:** `rx_valid` rises 1 clock after the stop-bit sample edge. Sample points sit 2 clocks late due to the synchroniser.
- **Simultaneous FIFO write and pop when full:** the pop frees a slot, but `tx_ready` was low, so no write occurs.

## Test plan
Common parameters: CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, 16 clocks/bit), DATA_BITS=8, PARITY=2, STOP_BITS=1, TX_DEPTH=4.

1. **TX single word:** write 0xA5 → `txd` falls 2 clocks later, then shows bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 16 clocks. `tx_busy` drops after 176 clocks total.
2. **TX FIFO full:** write 6 words without pause → `tx_ready` low after 4 accepted (one word is popped, so 5 are accepted in total). Frames are back-to-back with no idle gap, and the dropped word never appears.
3. **RX loopback:** drive `rxd` with the 0x3C frame → `rx_data` = 0x3C, `rx_valid` = 1, both error flags 0. With `rx_ready` held low, a second frame (0x55) gives an `rx_overrun` pulse and `rx_data` remains 0x3C.
4. **RX errors:**
   - Frame 0x01 with bad parity → `rx_parity_err` = 1.
   - Frame with stop bit low → `rx_frame_err` = 1.
   - An 8-clock low glitch → no `rx_valid`.
5. **Reset mid-frame:** assert `rst_n` low during the TX DATA state → `txd` = 1 immediately, `tx_busy` = 0. After release, a new write transmits cleanly.
6. **Format sweep:** DATA_BITS=7, PARITY=1, STOP_BITS=2 → 0x41 frame is 11 bits (176 clocks) with odd parity bit 1, and RX decodes it with no errors.

Source files
------------

// File: rtl/uart_xcvr.sv
// UART transceiver with a TX FIFO and a 16x-oversampled RX. txd falls 2 clocks after the first write; rx_valid rises 1 clock after the stop sample.
// Backpressure: tx_ready drops while the FIFO is full; an unconsumed rx word makes later words drop and pulse rx_overrun.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign wr_rdy = (count != (AW+1)'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

module uart_xcvr #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 rxd,
  output logic                 txd
);
  localparam int DIV      = CLK_HZ / (16 * BAUD);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int BCW      = $clog2(BIT_CLKS + 1);
  localparam int DVW      = $clog2(DIV + 1);
  localparam int IW       = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t            tx_state, tx_next;
  logic                 fifo_vld, fifo_pop;
  logic [DATA_BITS-1:0] fifo_dat, tx_shift;
  logic [BCW-1:0]       tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic                 tx_par, tx_bit_done, tx_line_busy;

  sync_fifo #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (tx_valid),
    .wr_rdy (tx_ready),
    .wr_dat (tx_data),
    .rd_vld (fifo_vld),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_dat)
  );

  assign tx_bit_done = (tx_cnt == BCW'(BIT_CLKS - 1));
  // txd lags the state by one register, so the line stays busy one clock past TX_IDLE
  assign tx_busy     = fifo_vld | (tx_state != TX_IDLE) | tx_line_busy;

  always_comb begin
    tx_next  = tx_state;
    fifo_pop = 1'b0;
    case (tx_state)
      TX_IDLE:   if (fifo_vld) begin tx_next = TX_START; fifo_pop = 1'b1; end
      TX_START:  if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_done && tx_idx == IW'(DATA_BITS - 1))
                   tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
      TX_STOP:   if (tx_bit_done && tx_idx == IW'(STOP_BITS - 1)) begin
                   if (fifo_vld) begin tx_next = TX_START; fifo_pop = 1'b1; end
                   else tx_next = TX_IDLE;
                 end
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      tx_par       <= 1'b0;
      tx_line_busy <= 1'b0;
      txd          <= 1'b1;
    end else begin
      tx_state     <= tx_next;
      tx_line_busy <= (tx_state != TX_IDLE);
      if (tx_state == TX_IDLE || tx_bit_done) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      if (tx_next != tx_state) tx_idx <= '0;
      else if (tx_bit_done) tx_idx <= tx_idx + 1'b1;
      if (fifo_pop) begin
        tx_shift <= fifo_dat;
        tx_par   <= (PARITY == 1) ? ~^fifo_dat : ^fifo_dat;
      end else if (tx_state == TX_DATA && tx_bit_done) begin
        tx_shift <= tx_shift >> 1;
      end
      case (tx_state)
        TX_START:  txd <= 1'b0;
        TX_DATA:   txd <= tx_shift[0];
        TX_PARITY: txd <= tx_par;
        default:   txd <= 1'b1;
      endcase
    end
  end

  rx_state_t            rx_state, rx_next;
  logic [1:0]           rxd_sync;
  logic                 rxd_s, rxd_prev;
  logic [DVW-1:0]       div_cnt;
  logic [3:0]           tick_cnt;
  logic                 tick, rx_sample;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_pbit, rx_done, rx_stop_bad, rx_par_bad;

  assign rxd_s     = rxd_sync[1];
  assign tick      = (div_cnt == DVW'(DIV - 1));
  // mid-bit: 7 ticks after the edge for the start bit, every 16 ticks thereafter
  assign rx_sample = (rx_state != RX_IDLE) && tick &&
                     (tick_cnt == ((rx_state == RX_START) ? 4'd7 : 4'd15));
  assign rx_par_bad = (PARITY == 1) ? ~(^rx_shift ^ rx_pbit) :
                      (PARITY == 2) ?  (^rx_shift ^ rx_pbit) : 1'b0;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rxd_prev && !rxd_s) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_sample && rx_idx == IW'(DATA_BITS - 1))
                   rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_sync    <= 2'b11;
      rxd_prev    <= 1'b1;
      rx_state    <= RX_IDLE;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_pbit     <= 1'b0;
      rx_done     <= 1'b0;
      rx_stop_bad <= 1'b0;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      rxd_prev <= rxd_s;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (rx_sample) tick_cnt <= '0;
        else if (tick) tick_cnt <= tick_cnt + 1'b1;
      end
      if (rx_state != RX_DATA) rx_idx <= '0;
      else if (rx_sample) rx_idx <= rx_idx + 1'b1;
      if (rx_state == RX_DATA && rx_sample) rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
      if (rx_state == RX_PARITY && rx_sample) rx_pbit <= rxd_s;
      rx_done <= (rx_state == RX_STOP) && rx_sample;
      if (rx_state == RX_STOP && rx_sample) rx_stop_bad <= ~rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_done) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          rx_parity_err <= rx_par_bad;
          rx_frame_err  <= rx_stop_bad;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr: instance A (8E1) driven from the bench, instance B (7O2) looped txd->rxd.
// Expected line waveforms and decoded words come from a frame builder working on plain bit arithmetic.
module tb_uart_xcvr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, tx_busy_a, rx_valid_a, rx_ready_a;
  logic       rx_perr_a, rx_ferr_a, rx_ovr_a, rxd_a, txd_a;
  logic [6:0] tx_data_b, rx_data_b;
  logic       tx_valid_b, tx_ready_b, tx_busy_b, rx_valid_b, rx_ready_b;
  logic       rx_perr_b, rx_ferr_b, rx_ovr_b, txd_b;

  uart_xcvr #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
              .STOP_BITS(1), .TX_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_busy(tx_busy_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_parity_err(rx_perr_a),
    .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a), .rxd(rxd_a), .txd(txd_a));

  uart_xcvr #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
              .STOP_BITS(2), .TX_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_busy(tx_busy_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_parity_err(rx_perr_b),
    .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b), .rxd(txd_b), .txd(txd_b));

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt  = 0;

  always @(negedge clk) if (rx_ovr_a === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line frame: start 0, data LSB first, optional parity, stop bits (the first may be forced low)
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int db, input int par,
                                           input logic bad_par, input logic bad_stop);
    logic [15:0] f;
    int ones, pos;
    f = 16'hFFFF;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    pos = 1 + db;
    if (par != 0) begin
      f[pos] = ((par == 2) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ bad_par;
      pos++;
    end
    f[pos] = ~bad_stop;
    return f;
  endfunction

  task automatic write_a(input logic [7:0] d, output logic acc);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    acc        = tx_ready_a;
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples every clock of every bit period
  task automatic tx_capture(input logic sel_b, input logic [15:0] fr, input int nb,
                            input string tag, output int waited, output logic busy_last);
    logic [15:0] obs;
    waited = 0;
    busy_last = 1'b0;
    while (((sel_b ? txd_b : txd_a) !== 1'b0) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, 32'(sel_b ? txd_b : txd_a), 0);
    for (int b = 0; b < nb; b++) begin
      obs = '0;
      for (int k = 0; k < 16; k++) begin
        obs[k]    = sel_b ? txd_b : txd_a;
        busy_last = sel_b ? tx_busy_b : tx_busy_a;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(obs), fr[b] ? 32'hFFFF : 32'h0);
    end
  endtask

  task automatic rx_drive(input logic [15:0] fr, input int nb);
    for (int b = 0; b < nb; b++) begin
      rxd_a = fr[b];
      repeat (16) @(negedge clk);
    end
    rxd_a = 1'b1;
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    int w = 0;
    while (rx_valid_a !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, 32'(rx_valid_a), 1);
    check({tag, "_data"},  32'(rx_data_a), 32'(d));
    check({tag, "_perr"},  32'(rx_perr_a), 32'(pe));
    check({tag, "_ferr"},  32'(rx_ferr_a), 32'(fe));
  endtask

  task automatic rx_consume(input string tag);
    rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
    check({tag, "_cleared"}, 32'(rx_valid_a), 0);
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] q[$];
  logic [7:0] d8;
  logic [6:0] d7;
  logic       acc, busy_last, bp, bs;
  logic       rdy_seen[6];
  int         waited, n_acc, lows, ovr0, w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; rxd_a = 1'b1;
    tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd",      32'(txd_a), 1);
    check("rst_tx_ready", 32'(tx_ready_a), 1);
    check("rst_tx_busy",  32'(tx_busy_a), 0);
    check("rst_rx_valid", 32'(rx_valid_a), 0);
    check("rst_rx_data",  32'(rx_data_a), 0);
    check("rst_errs",     32'({rx_perr_a, rx_ferr_a, rx_ovr_a}), 0);
    check("rst_txd_b",    32'(txd_b), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single words: first is 0xA5, then random
    for (int i = 0; i < 3; i++) begin
      d8 = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      write_a(d8, acc);
      check("tx1_accept", 32'(acc), 1);
      tx_capture(1'b0, mk_frame(9'(d8), 8, 2, 1'b0, 1'b0), 11, "tx1", waited, busy_last);
      check("tx1_latency", 32'(waited), 2);
      check("tx1_busy_end", 32'(busy_last), 1);
      check("tx1_busy_drop", 32'(tx_busy_a), 0);
      repeat (3) @(negedge clk);
    end

    // Six writes without pause into a 4-deep FIFO
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_data_a  = 8'($urandom_range(0, 255));
          tx_valid_a = 1'b1;
          rdy_seen[i] = tx_ready_a;
          if (tx_ready_a) begin
            q.push_back(tx_data_a);
            n_acc++;
          end
          @(negedge clk);
        end
        tx_valid_a = 1'b0;
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          d8 = q.pop_front();
          tx_capture(1'b0, mk_frame(9'(d8), 8, 2, 1'b0, 1'b0), 11, $sformatf("fifo%0d", f),
                     waited, busy_last);
          check("fifo_gap", 32'(waited), (f == 0) ? 2 : 0);
        end
      end
    join
    check("fifo_accepted", 32'(n_acc), 5);
    check("fifo_ready_4th", 32'(rdy_seen[4]), 1);
    check("fifo_ready_full", 32'(rdy_seen[5]), 0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    check("fifo_no_extra", 32'(lows), 0);
    check("fifo_idle_busy", 32'(tx_busy_a), 0);

    // RX: good word, then overrun with rx_ready held low
    rx_drive(mk_frame(9'h3C, 8, 2, 1'b0, 1'b0), 11);
    rx_expect("rx3c", 8'h3C, 1'b0, 1'b0);
    ovr0 = ovr_cnt;
    rx_drive(mk_frame(9'h55, 8, 2, 1'b0, 1'b0), 11);
    repeat (8) @(negedge clk);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 1);
    check("ovr_kept", 32'(rx_data_a), 32'h3C);
    check("ovr_valid", 32'(rx_valid_a), 1);
    rx_consume("ovr");

    rx_drive(mk_frame(9'h01, 8, 2, 1'b1, 1'b0), 11);
    rx_expect("rx_badpar", 8'h01, 1'b1, 1'b0);
    rx_consume("badpar");
    d8 = 8'($urandom_range(0, 255));
    rx_drive(mk_frame(9'(d8), 8, 2, 1'b0, 1'b1), 11);
    rx_expect("rx_badstop", d8, 1'b0, 1'b1);
    rx_consume("badstop");

    rxd_a = 1'b0;
    repeat (8) @(negedge clk);
    rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", 32'(rx_valid_a), 0);

    for (int i = 0; i < 6; i++) begin
      d8 = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      rx_drive(mk_frame(9'(d8), 8, 2, bp, bs), 11);
      rx_expect($sformatf("rx_rand%0d", i), d8, bp, bs);
      rx_consume("rand");
    end

    // Break: line held low longer than a frame
    rxd_a = 1'b0;
    repeat (12 * 16) @(negedge clk);
    rxd_a = 1'b1;
    rx_expect("rx_break", 8'h00, 1'b0, 1'b1);
    rx_consume("break");

    // Reset during the data bits with a second word queued
    write_a(8'($urandom_range(0, 255)), acc);
    write_a(8'($urandom_range(0, 255)), acc);
    repeat (38) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_txd", 32'(txd_a), 1);
    check("mrst_busy", 32'(tx_busy_a), 0);
    check("mrst_ready", 32'(tx_ready_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d8 = 8'($urandom_range(0, 255));
    write_a(d8, acc);
    tx_capture(1'b0, mk_frame(9'(d8), 8, 2, 1'b0, 1'b0), 11, "post_rst", waited, busy_last);
    check("post_rst_latency", 32'(waited), 2);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    check("post_rst_fifo_lost", 32'(lows), 0);

    // 7O2 instance in loopback: 0x41 first, then random words
    for (int i = 0; i < 3; i++) begin
      d7 = (i == 0) ? 7'h41 : 7'($urandom_range(0, 127));
      tx_data_b  = d7;
      tx_valid_b = 1'b1;
      @(negedge clk);
      tx_valid_b = 1'b0;
      tx_capture(1'b1, mk_frame(9'(d7), 7, 1, 1'b0, 1'b0), 11, "fmt", waited, busy_last);
      check("fmt_latency", 32'(waited), 2);
      w = 0;
      while (rx_valid_b !== 1'b1 && w < 64) begin
        @(negedge clk);
        w++;
      end
      check("fmt_rx_valid", 32'(rx_valid_b), 1);
      check("fmt_rx_data", 32'(rx_data_b), 32'(d7));
      check("fmt_rx_errs", 32'({rx_perr_b, rx_ferr_b}), 0);
      rx_ready_b = 1'b1;
      @(negedge clk);
      rx_ready_b = 1'b0;
      repeat (4) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
